rf_mp_scoreboard: RTL and testbench

Parametrised multi-port register file with per-register busy scoreboard for the pipeline processor. Provides NUM_RD combinational read ports with write-through bypass, NUM_WR write ports with fixed priority, a hardwired zero register, and a busy bit per register that the decode stage uses to detect RAW hazards on registers whose results are not yet written back. It sits between ID (reads, issue reservations) and WB (writes).

---
 rtl/rf_pkg.sv | 36 +++
 rtl/rf_bypass_rd.sv | 47 ++++
 rtl/rf_mp_scoreboard.sv | 90 +++++++++
 tb/tb_rf_mp_scoreboard.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file with busy scoreboard.
package rf_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  // Widest write-port configuration the hit helper can search.
  localparam int unsigned MAX_WR     = 8;
  localparam int unsigned MAX_ADDR_W = 8;
  localparam int unsigned WR_IDX_W   = 3;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

  typedef struct packed {
    logic                hit;
    logic [WR_IDX_W-1:0] idx;
  } wr_hit_t;

  // Ascending scan so the highest-index matching port is what remains.
  function automatic wr_hit_t wr_hit(
    input logic [MAX_WR-1:0]                 we,
    input logic [MAX_WR-1:0][MAX_ADDR_W-1:0] wa,
    input logic [MAX_ADDR_W-1:0]             addr
  );
    wr_hit_t res;
    res = '0;
    for (int w = 0; w < int'(MAX_WR); w++) begin
      if (we[w] && (wa[w] == addr)) begin
        res.hit = 1'b1;
        res.idx = WR_IDX_W'(w);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rf_bypass_rd.sv
// One read port: array value, write-through bypass from the highest matching
// write port, and the hardwired-zero force.
module rf_bypass_rd
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0]        ra,
  input  logic [DATA_W-1:0]        arr_val,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] wa,
  input  logic [NUM_WR*DATA_W-1:0] wd,
  output logic [DATA_W-1:0]        rd_c,
  output logic                     hit_c
);

  localparam logic ZERO_EN = (ZERO_REG != 0);

  logic [MAX_WR-1:0]                 we_x;
  logic [MAX_WR-1:0][MAX_ADDR_W-1:0] wa_x;
  wr_hit_t                           hit;
  logic [DATA_W-1:0]                 sel;

  always_comb begin
    we_x = '0;
    wa_x = '0;
    for (int w = 0; w < int'(NUM_WR); w++) begin
      we_x[w] = we[w];
      wa_x[w] = MAX_ADDR_W'(wa[w*ADDR_W +: ADDR_W]);
    end
    hit = wr_hit(we_x, wa_x, MAX_ADDR_W'(ra));

    sel = arr_val;
    if (hit.hit) begin
      for (int w = 0; w < int'(NUM_WR); w++) begin
        if (WR_IDX_W'(w) == hit.idx) sel = wd[w*DATA_W +: DATA_W];
      end
    end

    hit_c = hit.hit;
    rd_c  = (ZERO_EN && (ra == '0)) ? '0 : sel;
  end

endmodule

// File: rtl/rf_mp_scoreboard.sv
// Multi-port register file with per-register busy scoreboard for RAW hazard
// detection between issue (ID) and writeback (WB).
module rf_mp_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned DEPTH   = 2**ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] wa,
  input  logic [NUM_WR*DATA_W-1:0] wd,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     flush,
  output logic [DEPTH-1:0]         busy_vec
);

  localparam logic ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [NUM_RD-1:0] hit_c;

  // Array update: ascending port order lets the highest-index port win.
  always_comb begin
    mem_d = mem_q;
    for (int w = 0; w < int'(NUM_WR); w++) begin
      if (we[w] && !(ZERO_EN && (wa[w*ADDR_W +: ADDR_W] == '0))) begin
        mem_d[wa[w*ADDR_W +: ADDR_W]] = wd[w*DATA_W +: DATA_W];
      end
    end
  end

  // Busy update: writeback clears, a new reservation supersedes it, flush wins.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < int'(NUM_WR); w++) begin
      if (we[w]) busy_d[wa[w*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (issue_valid && !(ZERO_EN && (issue_addr == '0))) busy_d[issue_addr] = 1'b1;
    if (flush) busy_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    logic [ADDR_W-1:0] ra_k;
    assign ra_k = ra[k*ADDR_W +: ADDR_W];

    rf_bypass_rd #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .ra      (ra_k),
      .arr_val (mem_q[ra_k]),
      .we      (we),
      .wa      (wa),
      .wd      (wd),
      .rd_c    (rd[k*DATA_W +: DATA_W]),
      .hit_c   (hit_c[k])
    );

    // A register being written back this cycle is no longer pending.
    assign rd_busy[k] = ~flush & ~(ZERO_EN & (ra_k == '0)) & busy_q[ra_k] & ~hit_c[k];
  end

endmodule

// File: tb/tb_rf_mp_scoreboard.sv
// Self-checking bench for rf_mp_scoreboard: directed scenarios plus randomized
// traffic compared against a per-register behavioural model.
module tb_rf_mp_scoreboard;
  import rf_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NW-1:0]     we = '0;
  logic [NW*AW-1:0]  wa = '0;
  logic [NW*DW-1:0]  wd = '0;
  logic [NR*AW-1:0]  ra = '0;
  logic [NR*DW-1:0]  rd;
  logic [NR-1:0]     rd_busy;
  logic              issue_valid = 1'b0;
  reg_addr_t         issue_addr = '0;
  logic              flush = 1'b0;
  logic [DEPTH-1:0]  busy_vec;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]    m_mem [DEPTH];
  logic [DEPTH-1:0] m_busy;

  rf_mp_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
    .rd_busy(rd_busy), .issue_valid(issue_valid), .issue_addr(issue_addr),
    .flush(flush), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  // Reference model, one register at a time from the architectural rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
      m_busy = '0;
    end else begin
      logic [DEPTH-1:0] nb;
      nb = m_busy;
      for (int a = 1; a < DEPTH; a++) begin
        bit written;
        written = 0;
        for (int w = NW-1; w >= 0; w--) begin
          if (!written && we[w] && wa[w*AW +: AW] == a[AW-1:0]) begin
            m_mem[a] = wd[w*DW +: DW];
            written = 1;
          end
        end
        if (issue_valid && issue_addr == a[AW-1:0]) nb[a] = 1'b1;
        else if (written) nb[a] = 1'b0;
      end
      if (flush) nb = '0;
      m_busy = nb;
    end
  end

  function automatic logic [DW-1:0] exp_rd(input int k);
    logic [AW-1:0] a;
    a = ra[k*AW +: AW];
    if (a == 0) return '0;
    for (int w = NW-1; w >= 0; w--)
      if (we[w] && wa[w*AW +: AW] == a) return wd[w*DW +: DW];
    return m_mem[a];
  endfunction

  function automatic logic exp_rd_busy(input int k);
    logic [AW-1:0] a;
    a = ra[k*AW +: AW];
    if (flush || a == 0) return 1'b0;
    for (int w = 0; w < NW; w++)
      if (we[w] && wa[w*AW +: AW] == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [DW-1:0] rd_of(input int k);
    return rd[k*DW +: DW];
  endfunction

  task automatic idle();
    we = '0; wa = '0; wd = '0; issue_valid = 1'b0; issue_addr = '0; flush = 1'b0;
  endtask

  task automatic set_wr(input int w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[w] = 1'b1; wa[w*AW +: AW] = a; wd[w*DW +: DW] = d;
  endtask

  task automatic set_ra(input int k, input logic [AW-1:0] a);
    ra[k*AW +: AW] = a;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1; idle();
  endtask

  task automatic test_reset();
    idle(); set_ra(0, 5'd3); set_ra(1, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (rd_of(0) !== 32'h0) begin errors++; $display("FAIL reset_rd0 got=%h exp=0", rd_of(0)); end
    checks++; if (rd_of(1) !== 32'h0) begin errors++; $display("FAIL reset_rd1 got=%h exp=0", rd_of(1)); end
    checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL reset_rd_busy got=%b exp=00", rd_busy); end
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL reset_busy_vec got=%h exp=0", busy_vec); end
    rst_n = 1'b1;
  endtask

  task automatic test_write_bypass();
    next_cycle(); set_wr(0, 5'd5, 32'hDEADBEEF); set_ra(0, 5'd5);
    @(negedge clk);
    checks++; if (rd_of(0) !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_bypass got=%h exp=deadbeef", rd_of(0)); end
    next_cycle(); set_ra(0, 5'd5);
    @(negedge clk);
    checks++; if (rd_of(0) !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_stored got=%h exp=deadbeef", rd_of(0)); end
  endtask

  task automatic test_priority();
    next_cycle(); set_wr(0, 5'd7, 32'h11); set_wr(1, 5'd7, 32'h22); set_ra(1, 5'd7);
    @(negedge clk);
    checks++; if (rd_of(1) !== 32'h22) begin errors++; $display("FAIL prio_bypass got=%h exp=22", rd_of(1)); end
    next_cycle(); set_ra(1, 5'd7);
    @(negedge clk);
    checks++; if (rd_of(1) !== 32'h22) begin errors++; $display("FAIL prio_stored got=%h exp=22", rd_of(1)); end
  endtask

  task automatic test_busy();
    next_cycle(); issue_valid = 1'b1; issue_addr = 5'd9;
    next_cycle(); set_ra(0, 5'd9);
    @(negedge clk);
    checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL busy_rd_busy got=%b exp=1", rd_busy[0]); end
    checks++; if (busy_vec[9] !== 1'b1) begin errors++; $display("FAIL busy_vec9 got=%b exp=1", busy_vec[9]); end
    next_cycle(); set_ra(0, 5'd9); set_wr(1, 5'd9, 32'h55);
    @(negedge clk);
    checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL wb_rd_busy got=%b exp=0", rd_busy[0]); end
    checks++; if (rd_of(0) !== 32'h55) begin errors++; $display("FAIL wb_rd got=%h exp=55", rd_of(0)); end
    checks++; if (busy_vec[9] !== 1'b1) begin errors++; $display("FAIL wb_vec_same got=%b exp=1", busy_vec[9]); end
    next_cycle(); set_ra(0, 5'd9);
    @(negedge clk);
    checks++; if (busy_vec[9] !== 1'b0) begin errors++; $display("FAIL wb_vec_next got=%b exp=0", busy_vec[9]); end
  endtask

  task automatic test_set_clear();
    next_cycle(); issue_valid = 1'b1; issue_addr = 5'd4; set_wr(0, 5'd4, 32'h44);
    next_cycle(); issue_valid = 1'b1; issue_addr = 5'd0;
    @(negedge clk);
    checks++; if (busy_vec[4] !== 1'b1) begin errors++; $display("FAIL set_wins got=%b exp=1", busy_vec[4]); end
    next_cycle();
    @(negedge clk);
    checks++; if (busy_vec[0] !== 1'b0) begin errors++; $display("FAIL zero_busy got=%b exp=0", busy_vec[0]); end
  endtask

  task automatic test_flush();
    next_cycle(); issue_valid = 1'b1; issue_addr = 5'd2;
    next_cycle(); issue_valid = 1'b1; issue_addr = 5'd3;
    next_cycle(); flush = 1'b1; set_wr(0, 5'd6, 32'h99); set_ra(0, 5'd2); set_ra(1, 5'd6);
    @(negedge clk);
    checks++; if (busy_vec !== m_busy) begin errors++; $display("FAIL pre_flush_vec got=%h exp=%h", busy_vec, m_busy); end
    checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL flush_rd_busy got=%b exp=0", rd_busy[0]); end
    next_cycle(); set_ra(0, 5'd6);
    @(negedge clk);
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL flush_vec got=%h exp=0", busy_vec); end
    checks++; if (rd_of(0) !== 32'h99) begin errors++; $display("FAIL flush_write got=%h exp=99", rd_of(0)); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      next_cycle();
      for (int w = 0; w < NW; w++)
        if ($urandom_range(1, 0) == 1) set_wr(w, AW'($urandom_range(7, 0)), $urandom);
      for (int k = 0; k < NR; k++) set_ra(k, AW'($urandom_range(7, 0)));
      issue_valid = ($urandom_range(9, 0) < 4);
      issue_addr  = AW'($urandom_range(7, 0));
      flush       = ($urandom_range(19, 0) == 0);
      @(negedge clk);
      for (int k = 0; k < NR; k++) begin
        checks++;
        if (rd_of(k) !== exp_rd(k)) begin
          errors++; $display("FAIL rand_rd%0d cyc=%0d got=%h exp=%h", k, n, rd_of(k), exp_rd(k));
        end
        checks++;
        if (rd_busy[k] !== exp_rd_busy(k)) begin
          errors++; $display("FAIL rand_rd_busy%0d cyc=%0d got=%b exp=%b", k, n, rd_busy[k], exp_rd_busy(k));
        end
      end
      checks++;
      if (busy_vec !== m_busy) begin
        errors++; $display("FAIL rand_busy_vec cyc=%0d got=%h exp=%h", n, busy_vec, m_busy);
      end
    end
  endtask

  task automatic test_async_reset();
    next_cycle(); set_wr(0, 5'd5, 32'h1234); issue_valid = 1'b1; issue_addr = 5'd8;
    next_cycle(); set_wr(0, 5'd12, 32'hAB); set_ra(0, 5'd5); set_ra(1, 5'd8);
    @(negedge clk);
    checks++; if (rd_of(0) !== 32'h1234) begin errors++; $display("FAIL pre_rst_rd0 got=%h exp=1234", rd_of(0)); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rd_of(0) !== 32'h0) begin errors++; $display("FAIL async_rd0 got=%h exp=0", rd_of(0)); end
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL async_vec got=%h exp=0", busy_vec); end
    next_cycle(); set_ra(0, 5'd12);
    @(negedge clk);
    checks++; if (rd_of(0) !== 32'h0) begin errors++; $display("FAIL lost_write got=%h exp=0", rd_of(0)); end
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    test_reset();
    test_write_bypass();
    test_priority();
    test_busy();
    test_set_clear();
    test_flush();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
